// File: rtl/handshake_conn_fo_reg_if.sv
// Valid/ready/data handshake bundle shared by the fan-out ports.
// Senders own valid and data; receivers own ready.
interface handshake_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport sender (
    output valid,
    output data,
    input  ready
  );

  modport receiver (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/handshake_conn_fo_reg.sv
// Registered handshake fan-out: one upstream stream steered per beat
// to one of NUM_CHANNEL outputs, each with a one-entry holding slot.
module handshake_conn_fo_reg #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CHANNEL = 2,
  parameter int CNT_WIDTH   = 16,
  localparam int SEL_WIDTH  = $clog2(NUM_CHANNEL)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SEL_WIDTH-1:0] i_sel,
  handshake_if.receiver        rx_if,
  handshake_if.sender          tx_if [NUM_CHANNEL],
  output logic                 o_drop,
  output logic [CNT_WIDTH-1:0] o_drop_cnt,
  output logic                 o_idle
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [NUM_CHANNEL-1:0] slot_valid;
  logic [NUM_CHANNEL-1:0] tx_ready;
  logic [NUM_CHANNEL-1:0] load;
  logic                   rdy;
  logic                   in_range;
  logic                   accept;
  logic                   drop_d;

  // Out-of-range selects are always drained so the producer never stalls.
  always_comb begin
    in_range = 1'b0;
    rdy      = 1'b1;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (i_sel == SEL_WIDTH'(i)) begin
        in_range = 1'b1;
        rdy      = ~slot_valid[i] | tx_ready[i];
      end
    end
  end

  assign rx_if.ready = rdy;
  assign accept      = rx_if.valid & rdy;
  assign drop_d      = accept & ~in_range;

  for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_ch
    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] data_q;

    assign tx_ready[g]   = tx_if[g].ready;
    assign load[g]       = accept & (i_sel == SEL_WIDTH'(g));
    assign slot_valid[g] = (state_q == FULL);
    assign tx_if[g].valid = slot_valid[g];
    assign tx_if[g].data  = data_q;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        EMPTY: if (load[g]) state_d = FULL;
        FULL: begin
          if (load[g])
            state_d = FULL;
          else if (tx_ready[g])
            state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        if (load[g])
          data_q <= rx_if.data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_drop <= drop_d;
      if (drop_d && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

  assign o_idle = ~|slot_valid;

endmodule

// File: tb/tb_handshake_conn_fo_reg.sv
// Self-checking bench for handshake_conn_fo_reg: vector table,
// per-channel scoreboard queues and a cycle model of the slots.
module tb_handshake_conn_fo_reg;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sel;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic [NC-1:0] tx_rdy;
  logic [NC-1:0] tx_valid;
  logic [DW-1:0] tx_data [NC];
  logic          drop;
  logic [CW-1:0] drop_cnt;
  logic          idle;

  handshake_if #(.DATA_WIDTH(DW)) rx_bus ();
  handshake_if #(.DATA_WIDTH(DW)) tx_bus [NC] ();

  assign rx_bus.valid = rx_valid;
  assign rx_bus.data  = rx_data;

  for (genvar g = 0; g < NC; g++) begin : g_tx
    assign tx_bus[g].ready = tx_rdy[g];
    assign tx_valid[g]     = tx_bus[g].valid;
    assign tx_data[g]      = tx_bus[g].data;
  end

  handshake_conn_fo_reg #(
    .DATA_WIDTH (DW),
    .NUM_CHANNEL(NC),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sel     (sel),
    .rx_if     (rx_bus),
    .tx_if     (tx_bus),
    .o_drop    (drop),
    .o_drop_cnt(drop_cnt),
    .o_idle    (idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NC-1:0] m_full;
  logic          m_drop;
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] sbq [NC][$];

  typedef struct {
    logic          v;
    logic [1:0]    s;
    logic [DW-1:0] d;
    logic [NC-1:0] r;
    logic          er;
    logic [NC-1:0] ev;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat at the falling edge, check, then advance the model.
  task automatic step(input  logic          v,
                      input  logic [1:0]    s,
                      input  logic [DW-1:0] d,
                      input  logic [NC-1:0] r,
                      output logic          rdy_o,
                      output logic [NC-1:0] val_o);
    logic          mr;
    logic          acc;
    logic          pop;
    logic          ld;
    logic [DW-1:0] exp_d;
    int            si;
    rx_valid = v;
    sel      = s;
    rx_data  = d;
    tx_rdy   = r;
    #1;
    si = int'(s);
    mr = 1'b1;
    if (si < NC)
      mr = ~m_full[si] | r[si];
    rdy_o = rx_bus.ready;
    val_o = tx_valid;
    check("rx_ready", rx_bus.ready, mr);
    check("tx_valid", tx_valid, m_full);
    check("idle", idle, ~|m_full);
    check("drop", drop, m_drop);
    check("drop_cnt", drop_cnt, m_cnt);
    for (int c = 0; c < NC; c++) begin
      if (tx_valid[c] && r[c]) begin
        if (sbq[c].size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_d = sbq[c].pop_front();
          check($sformatf("tx%0d_data", c), tx_data[c], exp_d);
        end
      end
    end
    acc = v & mr;
    for (int c = 0; c < NC; c++) begin
      pop = m_full[c] & r[c];
      ld  = acc && (si == c);
      if (ld)
        sbq[c].push_back(d);
      m_full[c] = ld | (m_full[c] & ~pop);
    end
    m_drop = acc && (si >= NC);
    if (m_drop && (m_cnt != '1))
      m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic          rdy;
    logic [NC-1:0] val;
    int            n_acc;

    tbl[0]  = '{1'b1, 2'd1, 8'hA5, 3'b111, 1'b1, 3'b000};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b010};
    tbl[2]  = '{1'b1, 2'd0, 8'h11, 3'b110, 1'b1, 3'b000};
    tbl[3]  = '{1'b1, 2'd0, 8'h22, 3'b110, 1'b0, 3'b001};
    tbl[4]  = '{1'b1, 2'd0, 8'h22, 3'b110, 1'b0, 3'b001};
    tbl[5]  = '{1'b1, 2'd0, 8'h22, 3'b111, 1'b1, 3'b001};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b001};
    tbl[7]  = '{1'b1, 2'd0, 8'h33, 3'b110, 1'b1, 3'b000};
    tbl[8]  = '{1'b1, 2'd2, 8'h44, 3'b110, 1'b1, 3'b001};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 3'b110, 1'b0, 3'b101};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b001};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000};
    for (int i = 12; i < 17; i++)
      tbl[i] = '{1'b1, 2'd3, 8'h55, 3'b111, 1'b1, 3'b000};
    tbl[17] = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000};

    m_full   = '0;
    m_drop   = 1'b0;
    m_cnt    = '0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    sel      = '0;
    rx_data  = '0;
    tx_rdy   = '1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_valid", tx_valid, 0);
    check("rst_drop", drop, 0);
    check("rst_cnt", drop_cnt, 0);
    for (int c = 0; c < NC; c++)
      check("rst_data", tx_data[c], 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, rdy, val);
      check($sformatf("vec%0d_ready", i), rdy, tbl[i].er);
      check($sformatf("vec%0d_valid", i), val, tbl[i].ev);
      if (i == 0)
        check("a5_on_tx1", tx_data[1], 8'hA5);
      if (i == 16)
        check("drop_cnt_sat", drop_cnt, 3);
    end

    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'(i % 2), 8'(8'h80 + i), 3'b111, rdy, val);
      if (rdy)
        n_acc++;
    end
    check("b2b_accepts", n_acc, 8);
    step(1'b0, 2'd0, 8'h00, 3'b111, rdy, val);
    step(1'b0, 2'd0, 8'h00, 3'b111, rdy, val);

    step(1'b1, 2'd1, 8'h66, 3'b101, rdy, val);
    check("pre_rst_full", tx_valid[1], 1);
    check("pre_rst_cnt", drop_cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", tx_valid[1], 0);
    check("async_idle", idle, 1);
    check("async_cnt", drop_cnt, 0);
    m_full = '0;
    m_drop = 1'b0;
    m_cnt  = '0;
    for (int c = 0; c < NC; c++)
      sbq[c].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'd1, 8'h00, 3'b000, rdy, val);
    check("post_rst_ready", rdy, 1);
    step(1'b1, 2'd2, 8'h77, 3'b111, rdy, val);
    step(1'b0, 2'd0, 8'h00, 3'b111, rdy, val);

    for (int c = 0; c < NC; c++)
      check($sformatf("sb%0d_empty", c), sbq[c].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
